regfile_nrd: RTL and testbench

- Parametrised register file. Successor to the fixed 32-bit 8:1 read mux in the regfile datapath.
- Provides DEPTH = 2**ADDR_W storage entries of DATA_W bits, NUM_RD independent read ports and one write port.
- Supports an optional registered-read mode, write-to-read bypass and a synchronous bulk clear.
- Feeds the operand-fetch stage of the processor datapath.

---
 rtl/regfile_nrd.sv | 61 ++++++
 tb/tb_regfile_nrd.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_nrd.sv
// regfile_nrd: parametrised register file, NUM_RD read ports, one write port, optional registered read and bypass
module regfile_nrd #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int REG_READ = 0,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_valid
);
    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (clr)
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        else if (wr_en)
            mem[wr_addr] <= wr_data;

    genvar p;
    generate
        for (p = 0; p < NUM_RD; p++) begin : g_rd
            logic [ADDR_W-1:0] a;
            logic [DATA_W-1:0] d;
            logic              hit;
            assign a   = rd_addr[p*ADDR_W +: ADDR_W];
            // forwarding is gated by rst_n so a held-reset read still shows the zeroed array
            assign hit = (BYPASS != 0) && rst_n && wr_en && !clr && (a == wr_addr);
            assign d   = hit ? wr_data : mem[a];
            if (REG_READ != 0) begin : g_reg
                logic [DATA_W-1:0] q;
                logic              v;
                always_ff @(posedge clk or negedge rst_n)
                    if (!rst_n) begin
                        q <= '0;
                        v <= 1'b0;
                    end else begin
                        if (rd_en[p]) q <= d;
                        v <= rd_en[p];
                    end
                assign rd_data[p*DATA_W +: DATA_W] = q;
                assign rd_valid[p]                 = v;
            end else begin : g_comb
                assign rd_data[p*DATA_W +: DATA_W] = d;
                assign rd_valid[p]                 = rd_en[p];
            end
        end
    endgenerate
endmodule

// File: tb/tb_regfile_nrd.sv
// tb_regfile_nrd: directed vectors against combinational, registered and no-bypass variants sharing one stimulus
module tb_regfile_nrd;
    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [31:0] wd;
        logic        cl;
        logic [1:0]  re;
        logic [2:0]  ra0;
        logic [2:0]  ra1;
        logic [31:0] e0;
        logic [31:0] e1;
        logic [1:0]  ev;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        clr = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [31:0] wr_data = '0;
    logic [1:0]  rd_en = '0;
    logic [2:0]  ra0 = '0;
    logic [2:0]  ra1 = '0;
    logic [5:0]  rd_addr;
    logic [63:0] dc, dr, dn;
    logic [1:0]  vc, vr, vn;

    int checks = 0;
    int errors = 0;
    vec_t tbl [16];
    logic [31:0] vals [8];

    assign rd_addr = {ra1, ra0};

    always #5 clk = ~clk;

    regfile_nrd #(.REG_READ(0), .BYPASS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dc), .rd_valid(vc));
    regfile_nrd #(.REG_READ(1), .BYPASS(1)) u_r (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dr), .rd_valid(vr));
    regfile_nrd #(.REG_READ(0), .BYPASS(0)) u_n (
        .clk(clk), .rst_n(rst_n), .clr(clr), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(dn), .rd_valid(vn));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drv(input logic we, input logic [2:0] wa, input logic [31:0] wd, input logic cl,
                       input logic [1:0] re, input logic [2:0] a0, input logic [2:0] a1);
        wr_en = we; wr_addr = wa; wr_data = wd; clr = cl; rd_en = re; ra0 = a0; ra1 = a1;
    endtask

    task automatic apply(input vec_t v, input int idx);
        drv(v.we, v.wa, v.wd, v.cl, v.re, v.ra0, v.ra1);
        #2;
        chk($sformatf("tbl%0d_d0", idx), dc[31:0], v.e0);
        chk($sformatf("tbl%0d_d1", idx), dc[63:32], v.e1);
        chk($sformatf("tbl%0d_vld", idx), {30'd0, vc}, {30'd0, v.ev});
        @(negedge clk);
    endtask

    task automatic sweep_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            drv(0, 0, 0, 0, 2'b01, 3'(i), 0);
            #2;
            chk($sformatf("%s_a%0d", tag, i), dc[31:0], 32'h0);
            @(negedge clk);
        end
    endtask

    initial begin
        vals[0] = 32'hAAAABBBB; vals[1] = 32'hBBBBCCCC; vals[2] = 32'hCCCCCCCC; vals[3] = 32'hDDDDCCCC;
        vals[4] = 32'hEEEEBBBB; vals[5] = 32'hFFFFCCCC; vals[6] = 32'h2222CCCC; vals[7] = 32'h1111CCCC;
        for (int i = 0; i < 8; i++) begin
            tbl[i]     = '{1'b1, 3'(i), vals[i], 1'b0, 2'b00, 3'(i), 3'(i), vals[i], vals[i], 2'b00};
            tbl[i + 8] = '{1'b0, 3'd0, 32'h0, 1'b0, 2'b01, 3'(i), 3'(7 - i), vals[i], vals[7 - i], 2'b01};
        end

        // reset state
        #1 rst_n = 1'b0;
        rd_en = 2'b11;
        #2;
        chk("rst_c_data", dc[31:0], 32'h0);
        chk("rst_c_vld", {30'd0, vc}, 32'd3);
        chk("rst_r_data", dr[63:32], 32'h0);
        chk("rst_r_vld", {30'd0, vr}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // writes with bypass on both ports, then a read sweep
        for (int i = 0; i < 16; i++) apply(tbl[i], i);

        // registered read with latency and hold
        drv(0, 0, 0, 0, 2'b11, 3, 6);
        @(negedge clk);
        drv(0, 0, 0, 0, 2'b00, 3, 6);
        #2;
        chk("reg_d0", dr[31:0], 32'hDDDDCCCC);
        chk("reg_d1", dr[63:32], 32'h2222CCCC);
        chk("reg_vld", {30'd0, vr}, 32'd3);
        @(negedge clk);
        #2;
        chk("hold_d0", dr[31:0], 32'hDDDDCCCC);
        chk("hold_d1", dr[63:32], 32'h2222CCCC);
        chk("hold_vld", {30'd0, vr}, 32'd0);
        @(negedge clk);

        // bypass vs no bypass
        drv(1, 5, 32'h12345678, 0, 2'b10, 0, 5);
        #2;
        chk("byp_c_d1", dc[63:32], 32'h12345678);
        chk("byp_n_d1", dn[63:32], 32'hFFFFCCCC);
        chk("byp_c_vld", {30'd0, vc}, 32'd2);
        @(negedge clk);
        drv(0, 0, 0, 0, 2'b00, 0, 5);
        #2;
        chk("byp_r_d1", dr[63:32], 32'h12345678);
        chk("byp_r_vld", {30'd0, vr}, 32'd2);
        chk("byp_r_d0_hold", dr[31:0], 32'hDDDDCCCC);
        chk("byp_n_stored", dn[63:32], 32'h12345678);
        @(negedge clk);

        // clear beats a simultaneous write; reads see pre-clear values
        drv(1, 2, 32'h0BADF00D, 1, 2'b11, 2, 5);
        #2;
        chk("clr_c_d0", dc[31:0], 32'hCCCCCCCC);
        chk("clr_c_d1", dc[63:32], 32'h12345678);
        @(negedge clk);
        drv(0, 0, 0, 0, 2'b00, 0, 0);
        #2;
        chk("clr_r_d0", dr[31:0], 32'hCCCCCCCC);
        chk("clr_r_d1", dr[63:32], 32'h12345678);
        chk("clr_r_vld", {30'd0, vr}, 32'd3);
        @(negedge clk);
        sweep_zero("clr");

        // both ports read 7 while 0 is written
        drv(1, 7, 32'h1111CCCC, 0, 2'b00, 0, 0);
        @(negedge clk);
        drv(1, 0, 32'hAAAABBBB, 0, 2'b11, 7, 7);
        #2;
        chk("dual_c_d0", dc[31:0], 32'h1111CCCC);
        chk("dual_c_d1", dc[63:32], 32'h1111CCCC);
        @(negedge clk);
        drv(0, 0, 0, 0, 2'b11, 0, 7);
        #2;
        chk("dual_r_d0", dr[31:0], 32'h1111CCCC);
        chk("dual_r_d1", dr[63:32], 32'h1111CCCC);
        chk("dual_r_vld", {30'd0, vr}, 32'd3);
        chk("dual_c_e0", dc[31:0], 32'hAAAABBBB);
        @(negedge clk);
        #2;
        chk("dual_r_e0", dr[31:0], 32'hAAAABBBB);

        // asynchronous reset between edges, write during reset is lost
        #1 rst_n = 1'b0;
        drv(1, 3, 32'hDEADBEEF, 0, 2'b11, 0, 3);
        #1;
        chk("arst_r_d0", dr[31:0], 32'h0);
        chk("arst_r_d1", dr[63:32], 32'h0);
        chk("arst_r_vld", {30'd0, vr}, 32'd0);
        chk("arst_c_d0", dc[31:0], 32'h0);
        chk("arst_c_d1", dc[63:32], 32'h0);
        chk("arst_c_vld", {30'd0, vc}, 32'd3);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drv(0, 0, 0, 0, 2'b00, 0, 0);
        sweep_zero("arst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
